// File: rtl/cic_decim_ctrl_if.sv
// ---------------------------------------------------------------------------
// cic_decim_ctrl_if
// Groups the strobe, rate-request and status signals of cic_decim_ctrl.
//   Requests (master -> slave): en_i, act_i, rate_i, rate_stb_i, sync_i
//   Results  (slave -> master): act_o, act_out_o, cic_rst_o, val_o,
//                               busy_o, rate_o, rate_err_o
// The controller sits on the slave side. The sample-rate source and the
// rate-programming logic sit on the master side.
// ---------------------------------------------------------------------------
interface cic_decim_ctrl_if #(
    parameter int RATE_WIDTH = 7
);
    logic                  en_i;
    logic                  act_i;
    logic [RATE_WIDTH-1:0] rate_i;
    logic                  rate_stb_i;
    logic                  sync_i;
    logic                  act_o;
    logic                  act_out_o;
    logic                  cic_rst_o;
    logic                  val_o;
    logic                  busy_o;
    logic [RATE_WIDTH-1:0] rate_o;
    logic                  rate_err_o;

    modport master (
        output en_i, act_i, rate_i, rate_stb_i, sync_i,
        input  act_o, act_out_o, cic_rst_o, val_o, busy_o, rate_o, rate_err_o
    );

    modport slave (
        input  en_i, act_i, rate_i, rate_stb_i, sync_i,
        output act_o, act_out_o, cic_rst_o, val_o, busy_o, rate_o, rate_err_o
    );
endinterface

// File: rtl/cic_decim_ctrl.sv
// ---------------------------------------------------------------------------
// cic_decim_ctrl
// Sequencing controller for one CIC decimator. It gates input strobes into
// the CIC and divides them down to the decimated output strobe at a
// runtime-programmable rate. On a rate change or a resync it flushes the
// CIC. After each flush it hides the first DISCARD output strobes, so val_o
// flags only settled samples.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   bus (slave)  : en_i/act_i strobes, rate_i/rate_stb_i/sync_i requests;
//                  act_o/act_out_o/cic_rst_o drive the CIC;
//                  val_o/busy_o/rate_o/rate_err_o report status
// ---------------------------------------------------------------------------
module cic_decim_ctrl #(
    parameter int MAXRATE      = 64,
    parameter int RATE_WIDTH   = 7,
    parameter int DEFAULT_RATE = 8,
    parameter int DISCARD      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cic_decim_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_FLUSH,
        S_SETTLE,
        S_RUN
    } state_e;

    localparam logic [RATE_WIDTH-1:0] MAX_RATE_V = RATE_WIDTH'(MAXRATE);
    localparam logic [RATE_WIDTH-1:0] DEF_RATE_V = RATE_WIDTH'(DEFAULT_RATE);
    localparam logic [RATE_WIDTH-1:0] ONE_V      = RATE_WIDTH'(1);
    // Index of the last discarded strobe. When DISCARD is 0 the value is
    // never compared, because SETTLE is skipped.
    localparam logic [7:0]            DISC_LAST  = 8'(DISCARD - 1);

    state_e                state_q,   state_d;
    logic [RATE_WIDTH-1:0] cnt_q,     cnt_d;
    logic [RATE_WIDTH-1:0] rate_q,    rate_d;
    logic [7:0]            disc_q,    disc_d;
    logic                  act_out_q, act_out_d;
    logic                  val_q,     val_d;
    logic                  err_q,     err_d;

    logic rate_ok;
    logic flush_req;
    logic act_gated;
    logic act_out;
    logic wrap;

    // A sync is treated as a valid request that keeps the current rate.
    assign rate_ok   = bus.rate_stb_i && (bus.rate_i != '0) && (bus.rate_i <= MAX_RATE_V);
    assign flush_req = rate_ok || bus.sync_i;

    assign act_gated = (state_q != S_FLUSH) && bus.act_i && bus.en_i;
    // A pulse that falls on a disabled cycle is held in act_out_q and is
    // emitted once the enable returns, in step with the CIC.
    assign act_out   = act_out_q && bus.en_i;
    assign wrap      = act_gated && (cnt_q == rate_q - ONE_V);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rate_d    = rate_q;
        disc_d    = disc_q;
        act_out_d = act_out_q;
        err_d     = bus.rate_stb_i && !rate_ok;
        // A strobe is kept only if it is issued in RUN. The DISCARD-th strobe
        // is still issued in SETTLE, so it is dropped.
        val_d     = act_out && (state_q == S_RUN);

        // A wrap that coincides with a request still produces its pulse on
        // the next cycle. The request suppresses only val_o for that pulse.
        if (bus.en_i) begin
            act_out_d = wrap;
        end

        if (flush_req) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
            disc_d  = '0;
            if (rate_ok) begin
                rate_d = bus.rate_i;
            end
        end else if (bus.en_i) begin
            unique case (state_q)
                S_FLUSH: begin
                    cnt_d   = '0;
                    state_d = (DISCARD == 0) ? S_RUN : S_SETTLE;
                end
                S_SETTLE, S_RUN: begin
                    if (wrap) begin
                        cnt_d = '0;
                    end else if (act_gated) begin
                        cnt_d = cnt_q + ONE_V;
                    end
                    if ((state_q == S_SETTLE) && act_out) begin
                        if (disc_q == DISC_LAST) begin
                            state_d = S_RUN;
                        end else begin
                            disc_d = disc_q + 8'd1;
                        end
                    end
                end
                default: state_d = S_FLUSH;
            endcase
        end
    end

    // NOTE: sequential state updates with non-blocking assignments only, so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_FLUSH;
            cnt_q     <= '0;
            rate_q    <= DEF_RATE_V;
            disc_q    <= '0;
            act_out_q <= 1'b0;
            val_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rate_q    <= rate_d;
            disc_q    <= disc_d;
            act_out_q <= act_out_d;
            val_q     <= val_d;
            err_q     <= err_d;
        end
    end

    assign bus.act_o      = act_gated;
    assign bus.act_out_o  = act_out;
    assign bus.cic_rst_o  = (state_q == S_FLUSH);
    assign bus.val_o      = val_q;
    assign bus.busy_o     = (state_q != S_RUN);
    assign bus.rate_o     = rate_q;
    assign bus.rate_err_o = err_q;
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cic_decim_ctrl
// Self-checking bench for cic_decim_ctrl. A cycle model predicts the
// per-cycle outputs. Each expected act_out_o cycle is queued when the
// wrapping strobe is driven, and is popped when the DUT emits the pulse.
// Rate requests come from a vector table. Hand-written sequences cover
// reset, FLUSH extension, wrap/request collision and async reset.
// ---------------------------------------------------------------------------
module tb_cic_decim_ctrl;
    localparam int RW       = 7;
    localparam int DISCARD  = 16;
    localparam int S_FLUSH  = 0;
    localparam int S_SETTLE = 1;
    localparam int S_RUN    = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    cic_decim_ctrl_if #(.RATE_WIDTH(RW)) bus ();

    cic_decim_ctrl #(
        .MAXRATE      (64),
        .RATE_WIDTH   (RW),
        .DEFAULT_RATE (8),
        .DISCARD      (DISCARD)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state
    int st_m, cnt_m, disc_m, rate_m;
    bit pend_m, err_m, val_m;
    int sb_q[$];

    // Per-phase observation counters
    int n_ao, n_val, first_ao, phase0;

    typedef struct {
        bit         stb;
        logic [6:0] rate;
        bit         sync;
        logic [6:0] exp_rate;
        bit         exp_err;
        bit         exp_flush;
        int         run;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        st_m   = S_FLUSH;
        cnt_m  = 0;
        disc_m = 0;
        rate_m = 8;
        pend_m = 1'b0;
        err_m  = 1'b0;
        val_m  = 1'b0;
        sb_q.delete();
    endtask

    task automatic phase_mark();
        n_ao     = 0;
        n_val    = 0;
        first_ao = -1;
        phase0   = cyc;
    endtask

    task automatic reset_checks();
        check("rst_act_o",      bus.act_o,      0);
        check("rst_act_out_o",  bus.act_out_o,  0);
        check("rst_cic_rst_o",  bus.cic_rst_o,  1);
        check("rst_busy_o",     bus.busy_o,     1);
        check("rst_rate_o",     bus.rate_o,     8);
        check("rst_val_o",      bus.val_o,      0);
        check("rst_rate_err_o", bus.rate_err_o, 0);
    endtask

    // One clock cycle. It is called at posedge+1 and returns at the next
    // posedge+1.
    task automatic step(input bit a, input bit e, input bit s, input logic [6:0] r, input bit sy);
        bit valid, req, act_o_e, ao_e, wrap;
        bus.act_i      = a;
        bus.en_i       = e;
        bus.rate_stb_i = s;
        bus.rate_i     = r;
        bus.sync_i     = sy;

        act_o_e = (st_m != S_FLUSH) && a && e;
        ao_e    = pend_m && e;
        // A pending pulse on a disabled cycle slips to the next cycle.
        if (pend_m && !e && sb_q.size() > 0)
            sb_q[sb_q.size()-1] = sb_q[sb_q.size()-1] + 1;

        @(negedge clk_i);
        check("act_o",      bus.act_o,      act_o_e);
        check("cic_rst_o",  bus.cic_rst_o,  st_m == S_FLUSH);
        check("busy_o",     bus.busy_o,     st_m != S_RUN);
        check("rate_o",     bus.rate_o,     rate_m);
        check("rate_err_o", bus.rate_err_o, err_m);
        check("val_o",      bus.val_o,      val_m);

        if (bus.act_out_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("act_out_unexpected", bus.act_out_o, 0);
            end else begin
                check("act_out_cycle", cyc, sb_q.pop_front());
            end
            n_ao++;
            if (first_ao < 0) first_ao = cyc - phase0;
        end else if (sb_q.size() > 0 && sb_q[0] <= cyc) begin
            check("act_out_missing", bus.act_out_o, 1);
            void'(sb_q.pop_front());
        end
        if (bus.val_o === 1'b1) n_val++;

        // Advance the model to the next cycle.
        valid = s && (r >= 7'd1) && (r <= 7'd64);
        req   = valid || sy;
        wrap  = act_o_e && (cnt_m == rate_m - 1);
        err_m = s && !valid;
        val_m = ao_e && (st_m == S_RUN);
        if (e) pend_m = wrap;
        if (req) begin
            st_m   = S_FLUSH;
            cnt_m  = 0;
            disc_m = 0;
            if (valid) rate_m = int'(r);
        end else if (e) begin
            if (st_m == S_FLUSH) begin
                st_m = (DISCARD == 0) ? S_RUN : S_SETTLE;
            end else begin
                if (wrap) cnt_m = 0;
                else if (act_o_e) cnt_m++;
                if (st_m == S_SETTLE && ao_e) begin
                    disc_m++;
                    if (disc_m == DISCARD) st_m = S_RUN;
                end
            end
        end
        if (wrap) sb_q.push_back(cyc + 1);

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        bit found;

        // Columns: stb, rate, sync, exp_rate, exp_err, exp_flush, run cycles.
        vecs[0] = '{1'b1, 7'd4,   1'b0, 7'd4,  1'b0, 1'b1, 100};
        vecs[1] = '{1'b1, 7'd0,   1'b0, 7'd4,  1'b1, 1'b0, 20};
        vecs[2] = '{1'b1, 7'd65,  1'b0, 7'd4,  1'b1, 1'b0, 20};
        vecs[3] = '{1'b1, 7'd1,   1'b0, 7'd1,  1'b0, 1'b1, 40};
        vecs[4] = '{1'b1, 7'd64,  1'b0, 7'd64, 1'b0, 1'b1, 1300};
        vecs[5] = '{1'b1, 7'd127, 1'b0, 7'd64, 1'b1, 1'b0, 10};
        vecs[6] = '{1'b0, 7'd0,   1'b1, 7'd64, 1'b0, 1'b1, 10};
        vecs[7] = '{1'b1, 7'd8,   1'b1, 7'd8,  1'b0, 1'b1, 200};
        vecs[8] = '{1'b1, 7'd0,   1'b1, 7'd8,  1'b1, 1'b1, 10};

        bus.en_i       = 1'b1;
        bus.act_i      = 1'b1;
        bus.rate_i     = '0;
        bus.rate_stb_i = 1'b0;
        bus.sync_i     = 1'b0;

        // Reset and default rate: flush 1 cycle, first pulse at cycle 9,
        // 21 pulses in 171 cycles, and only pulses 17..21 give val_o.
        repeat (3) @(posedge clk_i);
        #1;
        reset_checks();
        rst_i = 1'b0;
        model_reset();
        phase_mark();
        repeat (171) step(1, 1, 0, 0, 0);
        check("p1_first_act_out", first_ao, 9);
        check("p1_act_out_count", n_ao, 21);
        check("p1_val_count",     n_val, 5);

        // Rate requests from the vector table.
        foreach (vecs[i]) begin
            step(1, 1, vecs[i].stb, vecs[i].rate, vecs[i].sync);
            check("tbl_rate_o",     bus.rate_o,     vecs[i].exp_rate);
            check("tbl_rate_err_o", bus.rate_err_o, vecs[i].exp_err);
            check("tbl_cic_rst_o",  bus.cic_rst_o,  vecs[i].exp_flush);
            repeat (vecs[i].run) step(1, 1, 0, 0, 0);
        end

        // A request while in FLUSH holds FLUSH one more cycle.
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        check("flush_ext_1", bus.cic_rst_o, 1);
        step(1, 1, 0, 0, 0);
        check("flush_ext_2", bus.cic_rst_o, 0);

        // Sparse input with enable gaps, at rate 4.
        step(1, 1, 1, 4, 0);
        for (int k = 0; k < 600; k++) begin
            step((k % 3) == 0, (k % 7) < 4, 0, 0, 0);
        end

        // Rate 8, then sync plus rate 16 on a wrap cycle.
        step(1, 1, 1, 8, 0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (st_m == S_RUN && cnt_m == 7) found = 1'b1;
            else step(1, 1, 0, 0, 0);
        end
        check("wrap_found", found, 1);
        step(1, 1, 1, 16, 1);
        check("coll_act_out_o", bus.act_out_o, 1);
        check("coll_cic_rst_o", bus.cic_rst_o, 1);
        check("coll_rate_o",    bus.rate_o,    16);
        step(1, 1, 0, 0, 0);
        check("coll_val_o",     bus.val_o,     0);
        phase_mark();
        repeat (288) step(1, 1, 0, 0, 0);
        check("p16_first_act_out", first_ao, 16);
        check("p16_act_out_count", n_ao, 17);
        check("p16_val_count",     n_val, 1);

        // Async reset in the middle of SETTLE, at rate 32.
        step(1, 1, 1, 32, 0);
        repeat (164) step(1, 1, 0, 0, 0);
        check("pre_rst_busy", bus.busy_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        reset_checks();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        phase_mark();
        repeat (171) step(1, 1, 0, 0, 0);
        check("p5_first_act_out", first_ao, 9);
        check("p5_act_out_count", n_ao, 21);
        check("p5_val_count",     n_val, 5);

        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
